// File: rtl/dds_tone_sequencer.sv
// dds_tone_sequencer
//   Control front-end for one dds phase-accumulator core. It produces the
//   periodic sampling_pulse and walks the tuning word K through a small
//   programmable tone table. Each entry holds a duration counted in samples.
//   Samples coming back from dds are registered for downstream logic.
//
// Ports
//   i_clk, i_reset        : single clock, synchronous active-high reset
//   i_wr_*                : tone-table write port (accepted in any state)
//   i_last_idx, i_loop    : playback range and wrap control
//   i_start, i_stop       : one-cycle control pulses (stop has priority)
//   o_k, o_sampling_pulse : drive to dds
//   i_new_sample_ready,
//   i_sample_in           : sample strobe and data from dds
//   o_sample_out,
//   o_sample_valid        : registered sample and its one-cycle strobe
//   o_busy, o_done,
//   o_cur_idx             : playback status
module dds_tone_sequencer #(
   parameter int  SAMPLE_DIV = 6,
   parameter int  DEPTH      = 8,
   parameter int  K_W        = 22,
   parameter int  DUR_W      = 16,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [K_W-1:0]   i_wr_k,
   input  logic [DUR_W-1:0] i_wr_dur,
   input  logic [AW-1:0]    i_last_idx,
   input  logic             i_loop,
   input  logic             i_start,
   input  logic             i_stop,
   output logic [K_W-1:0]   o_k,
   output logic             o_sampling_pulse,
   input  logic             i_new_sample_ready,
   input  logic [15:0]      i_sample_in,
   output logic [15:0]      o_sample_out,
   output logic             o_sample_valid,
   output logic             o_busy,
   output logic             o_done,
   output logic [AW-1:0]    o_cur_idx
);

   localparam int                DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(SAMPLE_DIV - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state, w_state_nxt;
   logic [K_W-1:0]     r_tab_k   [DEPTH];
   logic [DUR_W-1:0]   r_tab_dur [DEPTH];
   logic [K_W-1:0]     r_k;
   logic [AW-1:0]      r_idx;
   logic [DUR_W-1:0]   r_dur_cnt;
   logic [DIV_W-1:0]   r_div_cnt;
   logic               r_pulse;
   logic               r_done;
   logic [15:0]        r_sample_out;
   logic               r_sample_valid;

   logic               w_load;      // load table entry w_load_idx
   logic [AW-1:0]      w_load_idx;
   logic               w_clear;     // leaving RUN: K and index back to 0
   logic               w_done_nxt;
   logic               w_div_rst;   // (re)start: realign the sample divider
   logic               w_entry_end;
   logic [DUR_W-1:0]   w_load_dur;

   // The pulse cycle with dur_cnt==1 is the last sample of the entry; the
   // next entry is loaded on the edge that closes that cycle.
   assign w_entry_end = r_pulse && (r_dur_cnt == DUR_W'(1));
   assign w_load_dur  = (r_tab_dur[w_load_idx] == '0) ? DUR_W'(1) : r_tab_dur[w_load_idx];

   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_load_idx  = '0;
      w_clear     = 1'b0;
      w_done_nxt  = 1'b0;
      w_div_rst   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_stop) begin
               w_state_nxt = S_RUN;
               w_load      = 1'b1;
               w_div_rst   = 1'b1;
            end
         end
         S_RUN: begin
            if (i_stop) begin
               w_state_nxt = S_IDLE;
               w_clear     = 1'b1;
            end else if (i_start) begin
               w_load    = 1'b1;
               w_div_rst = 1'b1;
            end else if (w_entry_end) begin
               if (r_idx != i_last_idx) begin
                  w_load     = 1'b1;
                  w_load_idx = r_idx + AW'(1);
               end else if (i_loop) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_clear     = 1'b1;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_tab_k[i]   <= '0;
            r_tab_dur[i] <= '0;
         end
         r_k            <= '0;
         r_idx          <= '0;
         r_dur_cnt      <= '0;
         r_div_cnt      <= '0;
         r_pulse        <= 1'b0;
         r_done         <= 1'b0;
         r_sample_out   <= '0;
         r_sample_valid <= 1'b0;
      end else begin
         // Table writes only affect future loads; the playing K/dur are copies.
         if (i_wr_en) begin
            r_tab_k[i_wr_addr]   <= i_wr_k;
            r_tab_dur[i_wr_addr] <= i_wr_dur;
         end

         r_done <= w_done_nxt;

         if (w_load) begin
            r_idx     <= w_load_idx;
            r_k       <= r_tab_k[w_load_idx];
            r_dur_cnt <= w_load_dur;
         end else if (w_clear) begin
            r_idx     <= '0;
            r_k       <= '0;
            r_dur_cnt <= '0;
         end else if (r_pulse && r_dur_cnt != '0) begin
            r_dur_cnt <= r_dur_cnt - DUR_W'(1);
         end

         // Divider free-runs across entry changes so the pulse period is exact.
         if (w_state_nxt != S_RUN || w_div_rst) r_div_cnt <= '0;
         else if (r_div_cnt == DIV_MAX)         r_div_cnt <= '0;
         else                                   r_div_cnt <= r_div_cnt + DIV_W'(1);

         r_pulse <= (r_state == S_RUN) && (w_state_nxt == S_RUN) && !w_div_rst
                    && (r_div_cnt == DIV_MAX);

         r_sample_valid <= i_new_sample_ready;
         if (i_new_sample_ready) r_sample_out <= i_sample_in;
      end
   end

   assign o_k              = r_k;
   assign o_sampling_pulse = r_pulse;
   assign o_sample_out     = r_sample_out;
   assign o_sample_valid   = r_sample_valid;
   assign o_busy           = (r_state == S_RUN);
   assign o_done           = r_done;
   assign o_cur_idx        = r_idx;

endmodule
